instruction_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter and a word-addressed instruction memory that the debug unit loads before execution. It presents the IF/ID pipeline register (instruction, PC+4) to the decode stage and accepts the jump/branch redirect and stall back from it. It detects the HALT word and freezes fetch so the debug unit can read results.

---
 rtl/instruction_fetch.sv | 126 ++++++++++++
 tb/tb_instruction_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC and the instruction memory,
// drives the IF/ID register and runs a LOAD/RUN/HALTED control FSM for the debug unit.
module instruction_fetch #(
    parameter int                 NB_DATA     = 32,
    parameter int                 MEM_DEPTH   = 256,
    parameter int                 NB_MEM_ADDR = 8,
    parameter logic [NB_DATA-1:0] HALT_WORD   = 32'hFFFFFFFF
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_stall,
    input  logic                   i_jump,
    input  logic [NB_DATA-1:0]     i_addr2jump,
    input  logic                   i_start,
    input  logic                   i_we_imem,
    input  logic [NB_MEM_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0]     i_wr_data,
    output logic [NB_DATA-1:0]     o_instruction,
    output logic [NB_DATA-1:0]     o_pcounter4,
    output logic [NB_DATA-1:0]     o_pc,
    output logic                   o_halted,
    output logic                   o_loading
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0] instr_q, instr_d;
    logic [NB_DATA-1:0] pc4_q, pc4_d;

    logic [NB_DATA-1:0]     mem_q [MEM_DEPTH];
    logic [NB_MEM_ADDR-1:0] fetch_idx;
    logic [NB_DATA-1:0]     fetch_word;
    logic [NB_DATA-1:0]     pc_plus4;
    logic                   advance;
    logic                   unused_addr_lsbs;

    // Byte PC to word index; upper PC bits are dropped so fetch wraps around the memory.
    assign fetch_idx        = pc_q[NB_MEM_ADDR+1:2];
    assign fetch_word       = mem_q[fetch_idx];
    assign pc_plus4         = pc_q + NB_DATA'(4);
    assign advance          = i_enable && !i_stall;
    assign unused_addr_lsbs = ^i_addr2jump[1:0];

    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD && i_we_imem) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_LOAD;
            pc_q    <= '0;
            instr_q <= '0;
            pc4_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        case (state_q)
            ST_LOAD: begin
                pc_d    = '0;
                instr_d = '0;
                pc4_d   = '0;
                if (i_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A redirect arriving during a stall is dropped; decode re-issues it.
                if (advance) begin
                    if (i_jump) begin
                        instr_d = '0;
                        pc4_d   = '0;
                        pc_d    = {i_addr2jump[NB_DATA-1:2], 2'b00};
                    end else if (fetch_word == HALT_WORD) begin
                        instr_d = HALT_WORD;
                        pc4_d   = pc_plus4;
                        state_d = ST_HALTED;
                    end else begin
                        instr_d = fetch_word;
                        pc4_d   = pc_plus4;
                        pc_d    = pc_plus4;
                    end
                end
            end
            ST_HALTED: begin
                instr_d = '0;
                pc4_d   = '0;
                if (i_start) begin
                    pc_d    = '0;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
                pc_d    = '0;
                instr_d = '0;
                pc4_d   = '0;
            end
        endcase
    end

    assign o_instruction = instr_q;
    assign o_pcounter4   = pc4_q;
    assign o_pc          = pc_q;
    assign o_halted      = (state_q == ST_HALTED);
    assign o_loading     = (state_q == ST_LOAD);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus pushes expected IF/ID state per edge,
// a negedge monitor pops and compares.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_enable = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_jump = 1'b0;
    logic [31:0] i_addr2jump = '0;
    logic        i_start = 1'b0;
    logic        i_we_imem = 1'b0;
    logic [7:0]  i_wr_addr = '0;
    logic [31:0] i_wr_data = '0;
    logic [31:0] o_instruction, o_pcounter4, o_pc;
    logic        o_halted, o_loading;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] pc;
        logic        halted;
        logic        loading;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    instruction_fetch dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_enable     (i_enable),
        .i_stall      (i_stall),
        .i_jump       (i_jump),
        .i_addr2jump  (i_addr2jump),
        .i_start      (i_start),
        .i_we_imem    (i_we_imem),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .o_instruction(o_instruction),
        .o_pcounter4  (o_pcounter4),
        .o_pc         (o_pc),
        .o_halted     (o_halted),
        .o_loading    (o_loading)
    );

    always #5 clk = ~clk;

    // Monitor: compare every pending expectation at the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (o_instruction !== e.instr || o_pcounter4 !== e.pc4 || o_pc !== e.pc ||
                o_halted !== e.halted || o_loading !== e.loading) begin
                n_fail++;
                $display("FAIL %s: got instr=%h pc4=%h pc=%h halted=%b loading=%b, want instr=%h pc4=%h pc=%h halted=%b loading=%b",
                         nm, o_instruction, o_pcounter4, o_pc, o_halted, o_loading,
                         e.instr, e.pc4, e.pc, e.halted, e.loading);
            end else begin
                $display("ok   %s: instr=%h pc4=%h pc=%h halted=%b loading=%b",
                         nm, o_instruction, o_pcounter4, o_pc, o_halted, o_loading);
            end
        end
    end

    task automatic push_exp(input string nm, input logic [31:0] ei, input logic [31:0] ep4,
                            input logic [31:0] epc, input logic eh, input logic el);
        exp_t e;
        e.instr = ei; e.pc4 = ep4; e.pc = epc; e.halted = eh; e.loading = el;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // One clock edge with the currently driven inputs, then expect the given state.
    task automatic tick(input string nm, input logic [31:0] ei, input logic [31:0] ep4,
                        input logic [31:0] epc, input logic eh, input logic el);
        @(posedge clk);
        #1;
        push_exp(nm, ei, ep4, epc, eh, el);
        @(negedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d, input logic start);
        i_we_imem = 1'b1; i_wr_addr = a; i_wr_data = d; i_start = start;
        tick($sformatf("load[%0d]", a), 32'h0, 32'h0, 32'h0, 1'b0, !start);
        i_we_imem = 1'b0; i_start = 1'b0;
    endtask

    task automatic start_cmd(input string nm, input logic to_load);
        i_start = 1'b1;
        tick(nm, 32'h0, 32'h0, 32'h0, 1'b0, to_load);
        i_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        push_exp("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk); #1;
        i_rst_n = 1'b1;

        // Load program; start shares the cycle with the last write
        load_word(8'd0, 32'h20010005, 1'b0);
        load_word(8'd1, 32'h20020007, 1'b0);
        load_word(8'd2, 32'h00221820, 1'b0);
        load_word(8'd3, 32'hFFFFFFFF, 1'b1);
        tick("run0", 32'h20010005, 32'h4,  32'h4, 1'b0, 1'b0);
        tick("run1", 32'h20020007, 32'h8,  32'h8, 1'b0, 1'b0);
        tick("run2", 32'h00221820, 32'hC,  32'hC, 1'b0, 1'b0);
        tick("halt", 32'hFFFFFFFF, 32'h10, 32'hC, 1'b1, 1'b0);
        tick("drain", 32'h0, 32'h0, 32'hC, 1'b1, 1'b0);
        i_jump = 1'b1; i_addr2jump = 32'h40; i_stall = 1'b1;
        tick("halt_ignores_jump", 32'h0, 32'h0, 32'hC, 1'b1, 1'b0);
        i_jump = 1'b0; i_stall = 1'b0;

        // Stall test
        start_cmd("halted_to_load", 1'b1);
        start_cmd("load_to_run", 1'b0);
        tick("s_run0", 32'h20010005, 32'h4, 32'h4, 1'b0, 1'b0);
        tick("s_run1", 32'h20020007, 32'h8, 32'h8, 1'b0, 1'b0);
        i_stall = 1'b1;
        tick("stall1", 32'h20020007, 32'h8, 32'h8, 1'b0, 1'b0);
        tick("stall2", 32'h20020007, 32'h8, 32'h8, 1'b0, 1'b0);
        i_stall = 1'b0;
        tick("stall_release", 32'h00221820, 32'hC, 32'hC, 1'b0, 1'b0);
        tick("s_halt", 32'hFFFFFFFF, 32'h10, 32'hC, 1'b1, 1'b0);

        // Enable-low test
        start_cmd("e_to_load", 1'b1);
        start_cmd("e_to_run", 1'b0);
        tick("e_run0", 32'h20010005, 32'h4, 32'h4, 1'b0, 1'b0);
        tick("e_run1", 32'h20020007, 32'h8, 32'h8, 1'b0, 1'b0);
        i_enable = 1'b0;
        tick("disable1", 32'h20020007, 32'h8, 32'h8, 1'b0, 1'b0);
        tick("disable2", 32'h20020007, 32'h8, 32'h8, 1'b0, 1'b0);
        i_enable = 1'b1;
        tick("enable_release", 32'h00221820, 32'hC, 32'hC, 1'b0, 1'b0);
        tick("e_halt", 32'hFFFFFFFF, 32'h10, 32'hC, 1'b1, 1'b0);

        // Jump tests
        start_cmd("j_to_load", 1'b1);
        load_word(8'd8, 32'hABCD0000, 1'b0);
        load_word(8'd9, 32'h11111111, 1'b1);
        tick("j_run0", 32'h20010005, 32'h4, 32'h4, 1'b0, 1'b0);
        tick("j_run1", 32'h20020007, 32'h8, 32'h8, 1'b0, 1'b0);
        i_jump = 1'b1; i_addr2jump = 32'h22;
        tick("jump_flush", 32'h0, 32'h0, 32'h20, 1'b0, 1'b0);
        i_jump = 1'b0;
        tick("jump_target", 32'hABCD0000, 32'h24, 32'h24, 1'b0, 1'b0);
        tick("jump_next", 32'h11111111, 32'h28, 32'h28, 1'b0, 1'b0);
        i_jump = 1'b1; i_addr2jump = 32'h8;
        tick("jump_to_8", 32'h0, 32'h0, 32'h8, 1'b0, 1'b0);
        i_addr2jump = 32'h40; i_stall = 1'b1;
        tick("jump_during_stall", 32'h0, 32'h0, 32'h8, 1'b0, 1'b0);
        i_jump = 1'b0; i_stall = 1'b0;
        tick("resume_at_8", 32'h00221820, 32'hC, 32'hC, 1'b0, 1'b0);
        i_jump = 1'b1; i_addr2jump = 32'h0;
        tick("jump_over_halt", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        i_addr2jump = 32'h400;
        tick("jump_400", 32'h0, 32'h0, 32'h400, 1'b0, 1'b0);
        i_jump = 1'b0;
        tick("wrap_fetch", 32'h20010005, 32'h404, 32'h404, 1'b0, 1'b0);

        // Writes and start are ignored in RUN
        i_we_imem = 1'b1; i_wr_addr = 8'd2; i_wr_data = 32'hDEADBEEF; i_start = 1'b1;
        tick("run_write_ignored", 32'h20020007, 32'h408, 32'h408, 1'b0, 1'b0);
        i_we_imem = 1'b0; i_start = 1'b0;
        tick("mem_unchanged", 32'h00221820, 32'h40C, 32'h40C, 1'b0, 1'b0);

        // Asynchronous reset mid-RUN, between clock edges
        @(posedge clk); #2;
        i_rst_n = 1'b0;
        #1;
        push_exp("async_reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk); #1;
        i_rst_n = 1'b1;

        // Memory survives reset
        start_cmd("r_to_run", 1'b0);
        tick("r_run0", 32'h20010005, 32'h4, 32'h4, 1'b0, 1'b0);

        // Let the monitor drain, bounded
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
